// File: rtl/seq_mult.sv
// seq_mult: bit-serial signed fixed-point multiplier, LSB-first in and out.
// Build option: define SEQ_MULT_ROUND_EN for round-half-up instead of floor.
module seq_mult #(
    parameter int NB_DATA_IN   = 4,
    parameter int NBF_DATA_IN  = 3,
    parameter int NB_DATA_OUT  = 4,
    parameter int NBF_DATA_OUT = 3
) (
    input  logic                  clock,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_data,
    input  logic [NB_DATA_IN-1:0] coeff,
    output logic                  o_data
);

    localparam int N  = NB_DATA_IN;
    localparam int CW = $clog2(N);
    localparam int PW = 2 * N + 1;
    localparam int S  = 2 * NBF_DATA_IN - NBF_DATA_OUT;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic signed [PW-1:0] MAXV = PW'((2 ** (NB_DATA_OUT - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = PW'(-(2 ** (NB_DATA_OUT - 1)));
    localparam logic [N-1:0] MAXN = N'((2 ** (NB_DATA_OUT - 1)) - 1);
    localparam logic [N-1:0] MINN = N'(-(2 ** (NB_DATA_OUT - 1)));

`ifdef SEQ_MULT_ROUND_EN
    // Half an output LSB; zero when no bits are dropped.
    localparam int RND = (2 ** S) / 2;
`endif

    logic [CW-1:0]        cnt;
    logic [N-2:0]         in_sr;
    logic [N-1:0]         out_sr;
    logic [N-1:0]         word;
    logic signed [PW-1:0] wx;
    logic signed [PW-1:0] cx;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic [N-1:0]         sat;

    assign word   = {i_data, in_sr};
    assign o_data = out_sr[0];

    // Full product of the completed word, rescaled and clamped to the output range.
    always_comb begin
        wx = {{(PW - N){word[N-1]}}, word};
        cx = {{(PW - N){coeff[N-1]}}, coeff};
        prod = wx * cx;
`ifdef SEQ_MULT_ROUND_EN
        prod = prod + PW'(RND);
`endif
        shifted = prod >>> S;
        if (shifted > MAXV) begin
            sat = MAXN;
        end else if (shifted < MINV) begin
            sat = MINN;
        end else begin
            sat = shifted[N-1:0];
        end
    end

    // Frame position: count N enabled cycles, then wrap to the next LSB.
    always_ff @(posedge clock or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Collect incoming bits; the newest bit enters at the MSB end.
    always_ff @(posedge clock or posedge i_rst) begin
        if (i_rst) begin
            in_sr <= '0;
        end else if (i_en) begin
            in_sr <= word[N-1:1];
        end
    end

    // Load the product at frame end, otherwise stream it out with sign fill.
    always_ff @(posedge clock or posedge i_rst) begin
        if (i_rst) begin
            out_sr <= '0;
        end else if (i_en) begin
            if (cnt == LAST) begin
                out_sr <= sat;
            end else begin
                out_sr <= {out_sr[N-1], out_sr[N-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed table, random stream, stall and async reset checks.
// Honours SEQ_MULT_ROUND_EN the same way as the design.
module tb_seq_mult;

    localparam int S = 3;

    logic       clock = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b0;
    logic       i_data = 1'b0;
    logic [3:0] coeff = 4'b0;
    logic       o_data;

    int   nvec = 0;
    int   nerr = 0;
    logic exp_q[$];
    logic obs[$];
    logic last_o = 1'b0;

    typedef struct {
        logic [3:0] w;
        logic [3:0] c;
        logic [3:0] want;
    } vec_t;

    vec_t       tbl[4];
    logic [3:0] refs[$];

    seq_mult dut (
        .clock (clock),
        .i_rst (i_rst),
        .i_en  (i_en),
        .i_data(i_data),
        .coeff (coeff),
        .o_data(o_data)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] ref_mult(input logic [3:0] w, input logic [3:0] c);
        int a;
        int b;
        int p;
        int r;
        logic [31:0] rv;
        a = $signed(w);
        b = $signed(c);
        p = a * b;
`ifdef SEQ_MULT_ROUND_EN
        p = p + (1 << (S - 1));
`endif
        r = p >>> S;
        if (r > 7) r = 7;
        if (r < -8) r = -8;
        rv = r;
        return rv[3:0];
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, want, $time);
        end
    endtask

    task automatic tick(input logic en, input logic d);
        logic e;
        i_en = en;
        i_data = d;
        @(posedge clock);
        #1;
        if (en) begin
            obs.push_back(o_data);
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL model: no expected bit at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("bit", {3'b0, o_data}, {3'b0, e});
            end
        end else begin
            check("hold", {3'b0, o_data}, {3'b0, last_o});
        end
        last_o = o_data;
    endtask

    task automatic send_word(input logic [3:0] w, input logic [3:0] c, input int stall_after);
        logic [3:0] r;
        r = ref_mult(w, c);
        for (int k = 0; k < 4; k++) exp_q.push_back(r[k]);
        coeff = c;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, w[k]);
            if (k == stall_after) begin
                for (int s = 0; s < 3; s++) tick(1'b0, ~w[k]);
            end
        end
    endtask

    task automatic check_frame(input string nm, input int j, input logic [3:0] want);
        int b;
        b = 4 * j + 3;
        if (obs.size() < b + 4) begin
            nvec++;
            nerr++;
            $display("FAIL %s: frame %0d missing", nm, j);
        end else begin
            check(nm, {obs[b+3], obs[b+2], obs[b+1], obs[b]}, want);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_data = i[0];
            @(posedge clock);
            #1;
            check("rst", {3'b0, o_data}, 4'b0);
        end
        i_rst = 1'b0;
        exp_q.delete();
        obs.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
        last_o = 1'b0;
    endtask

    initial begin
        logic [3:0] w;

`ifdef SEQ_MULT_ROUND_EN
        tbl[0] = '{4'b0100, 4'b1101, 4'b1111};
`else
        tbl[0] = '{4'b0100, 4'b1101, 4'b1110};
`endif
        tbl[1] = '{4'b0111, 4'b1101, 4'b1101};
        tbl[2] = '{4'b1000, 4'b1000, 4'b0111};
        tbl[3] = '{4'b1000, 4'b0111, 4'b1001};

        do_reset();
        for (int i = 0; i < 4; i++) send_word(tbl[i].w, tbl[i].c, -1);
        send_word(4'b0, 4'b0, -1);
        for (int i = 0; i < 4; i++) check_frame("table", i, tbl[i].want);

        do_reset();
        refs.delete();
        for (int i = 0; i < 50; i++) begin
            w = 4'($urandom_range(0, 15));
            refs.push_back(ref_mult(w, 4'b1101));
            send_word(w, 4'b1101, -1);
        end
        send_word(4'b0, 4'b0, -1);
        for (int i = 0; i < 50; i++) check_frame("random", i, refs[i]);

        do_reset();
        send_word(4'b0101, 4'b1101, -1);
        send_word(4'b0110, 4'b1101, 1);
        send_word(4'b0011, 4'b1011, 2);
        send_word(4'b0, 4'b0, -1);
        check_frame("stall", 0, ref_mult(4'b0101, 4'b1101));
        check_frame("stall", 1, ref_mult(4'b0110, 4'b1101));
        check_frame("stall", 2, ref_mult(4'b0011, 4'b1011));

        do_reset();
        send_word(4'b0111, 4'b1101, -1);
        coeff = 4'b0111;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst", {3'b0, o_data}, 4'b0);
        @(posedge clock);
        #1;
        check("rst_hold", {3'b0, o_data}, 4'b0);
        i_rst = 1'b0;
        exp_q.delete();
        obs.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
        last_o = 1'b0;
        send_word(4'b0111, 4'b1101, -1);
        send_word(4'b0, 4'b0, -1);
        check_frame("restart", 0, 4'b1101);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
# seq_mult

Bit-serial fixed-point multiplier. It takes a signed two's-complement sample one bit per cycle, LSB first, and multiplies each complete word by a parallel signed coefficient. The rescaled, saturated product is emitted bit-serially, LSB first, on a single output line. It sits in serial datapaths (e.g. serial FIR taps) where one wire carries each operand stream.

## Interface
- NB_DATA_IN, 4: width of input word and of coeff (frame length in cycles).
- NBF_DATA_IN, 3: fractional bits of input word and coeff (Q(NB-NBF).NBF).
- NB_DATA_OUT, 4: width of output word; must satisfy NB_DATA_OUT <= NB_DATA_IN.
- NBF_DATA_OUT, 3: fractional bits of output; must satisfy NBF_DATA_OUT <= 2*NBF_DATA_IN.
- clock  input  1  sole clock, rising-edge.
- i_rst  input  1  reset, asynchronous, active-high; clears all state.
- i_en  input  1  clock enable; when low all state freezes.
- i_data  input  1  serial input sample bit, LSB first.
- coeff  input  NB_DATA_IN  signed coefficient, same format as input word.
- o_data  output  1  registered serial product bit, LSB first.

## Operation
- Bit counter, $clog2(NB_DATA_IN) bits, counts enabled cycles 0..NB_DATA_IN-1 and wraps. Count 0 marks the LSB of a frame.
- Each enabled edge shifts i_data into an input shift register (MSB end, shifting right).
- On the enabled edge where count == NB_DATA_IN-1 (frame complete):
  - the word is {i_data, shift register}.
  - full product P = word × coeff, signed, 2*NB_DATA_IN bits, 2*NBF_DATA_IN fractional bits; coeff is sampled on this edge only.
  - P is shifted arithmetically right by S = 2*NBF_DATA_IN - NBF_DATA_OUT, with floor truncation (see Configuration).
  - the result saturates to the signed NB_DATA_OUT range: max 0 followed by ones, min 1 followed by zeros.
  - the result is sign-extended to NB_DATA_IN bits and loaded into the output shift register.
- Other enabled edges shift the output register right by one, filling with its sign bit. o_data = register bit 0.
- i_en low: counter, input register and output register hold; o_data holds.
- Reset: counter = 0, both registers = 0, o_data = 0. Asserting reset mid-frame discards the partial word and the pending output; the next enabled cycle after release is bit 0 of a new frame.
- No handshake: the caller aligns frames to the first enabled cycle after reset release.

## Timing
- Let the input LSB be sampled at enabled edge t and the MSB at edge t+N-1, with N = NB_DATA_IN.
- Product bit k is valid on o_data after edge t+N-1+k, for k = 0..N-1.
- Latency: N enabled cycles, LSB-in to LSB-out.
- Output frames are contiguous and back-to-back with input frames, one frame out per N enabled cycles.
- Before the first frame completes, o_data = 0.
- Load and shift never coincide: at count N-1 the load takes precedence and the last bit of the previous output has already been presented.

## Configuration
- SEQ_MULT_ROUND_EN defined: add 2^(S-1) to P before the right shift (round half up), only when S > 0. Saturation is applied after rounding.
- Not defined: plain floor truncation.

## Test plan
- Reset held with i_en=1, toggling i_data -> o_data stays 0 and no frame completes. Release reset, feed 0100 (0.5) with coeff 1101 (-0.375) -> output frame 1110 (1111 with SEQ_MULT_ROUND_EN).
- Feed 0111 × coeff 1101 -> 1101 (-0.375) in both configurations.
- Feed 1000 × coeff 1000 (-1 × -1) -> saturates to 0111. Feed 1000 × coeff 0111 -> 1001.
- 50 back-to-back random words, coeff 1101 -> each output frame equals the reference-model product and is offset by exactly 4 enabled cycles.
- Drop i_en for 3 cycles mid-frame -> o_data and the frame position hold, and the result equals the un-stalled case. Assert i_rst mid-frame -> o_data goes 0 immediately (asynchronous) and framing restarts at bit 0.
